id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS core, sitting directly upstream of the EX-stage `ALU`. It latches decoded operands and control, resolves RAW hazards by forwarding EX/MEM and MEM/WB results, and detects load-use hazards. It drives the ALU's `ALUop`, `x` and `y` inputs.

---
 rtl/id_ex_stage_if.sv | 59 +++++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, pipeline control, forward sources and the
// registered EX-side outputs. The stage connects through the slave modport.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            id_valid;
  logic [3:0]      id_aluop;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_rd;
  logic [XLEN-1:0] id_rs_data;
  logic [XLEN-1:0] id_rt_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_shamt;
  logic [1:0]      id_src_sel;
  logic            id_reg_write;
  logic            id_mem_read;

  logic            stall;
  logic            flush;

  logic            exmem_reg_write;
  logic [RA_W-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [RA_W-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_result;

  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [3:0]      ex_aluop;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_x;
  logic [XLEN-1:0] ex_y;
  logic [XLEN-1:0] ex_store_data;
  logic            hazard_stall;

  modport master (
    output id_valid, id_aluop, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_sel, id_reg_write, id_mem_read,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_aluop, ex_rd,
           ex_x, ex_y, ex_store_data, hazard_stall
  );

  modport slave (
    input  id_valid, id_aluop, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_sel, id_reg_write, id_mem_read,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, ex_reg_write, ex_mem_read, ex_aluop, ex_rd,
           ex_x, ex_y, ex_store_data, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU, with operand routing and hazard detection.
// ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; without it, RAW hazards stall instead.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  localparam logic [3:0] ALUOP_NOP = 4'hd;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic [3:0]      aluop;
    logic [RA_W-1:0] rd;
`ifdef ID_EX_FWD_EN
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
`endif
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      shamt;
    logic [1:0]      src_sel;
  } stage_t;

  localparam stage_t BUBBLE = '{aluop: ALUOP_NOP, default: '0};

  stage_t          q;
  stage_t          d;
  stage_t          id_fields;
  logic [XLEN-1:0] op_rs;
  logic [XLEN-1:0] op_rt;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;
  logic            hazard;

  // Per-source operand resolution, before source select.
  always_comb begin
    op_rs = q.rs_data;
    op_rt = q.rt_data;
`ifdef ID_EX_FWD_EN
    if (q.rs != '0 && bus.exmem_reg_write && bus.exmem_rd == q.rs)
      op_rs = bus.exmem_result;
    else if (q.rs != '0 && bus.memwb_reg_write && bus.memwb_rd == q.rs)
      op_rs = bus.memwb_result;

    if (q.rt != '0 && bus.exmem_reg_write && bus.exmem_rd == q.rt)
      op_rt = bus.exmem_result;
    else if (q.rt != '0 && bus.memwb_reg_write && bus.memwb_rd == q.rt)
      op_rt = bus.memwb_result;
`endif
  end

  always_comb begin
    x = op_rs;
    y = op_rt;
    case (q.src_sel)
      2'b00: begin
        x = op_rs;
        y = op_rt;
      end
      2'b01: begin
        x = op_rs;
        y = q.imm;
      end
      2'b10: begin
        x = op_rt;
        y = {{(XLEN-5){1'b0}}, q.shamt};
      end
      default: begin
        x = op_rt;
        y = op_rs;
      end
    endcase
  end

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be covered by forwarding; rt is checked even if unused.
  always_comb begin
    hazard = bus.id_valid && q.valid && q.mem_read && q.rd != '0 &&
             (q.rd == bus.id_rs || q.rd == bus.id_rt);
  end
`else
  logic rs_raw;
  logic rt_raw;

  always_comb begin
    rs_raw = bus.id_rs != '0 &&
             ((q.valid && q.reg_write && q.rd == bus.id_rs) ||
              (bus.exmem_reg_write && bus.exmem_rd == bus.id_rs));
    rt_raw = bus.id_rt != '0 &&
             ((q.valid && q.reg_write && q.rd == bus.id_rt) ||
              (bus.exmem_reg_write && bus.exmem_rd == bus.id_rt));
    hazard = bus.id_valid && (rs_raw || rt_raw);
  end
`endif

  always_comb begin
    id_fields           = BUBBLE;
    id_fields.valid     = bus.id_valid;
    id_fields.reg_write = bus.id_reg_write;
    id_fields.mem_read  = bus.id_mem_read;
    id_fields.aluop     = bus.id_aluop;
    id_fields.rd        = bus.id_rd;
`ifdef ID_EX_FWD_EN
    id_fields.rs        = bus.id_rs;
    id_fields.rt        = bus.id_rt;
`endif
    id_fields.rs_data   = bus.id_rs_data;
    id_fields.rt_data   = bus.id_rt_data;
    id_fields.imm       = bus.id_imm;
    id_fields.shamt     = bus.id_shamt;
    id_fields.src_sel   = bus.id_src_sel;
  end

  always_comb begin
    d = q;
    if (bus.flush) begin
      d = BUBBLE;
    end else if (bus.stall) begin
`ifdef ID_EX_FWD_EN
      // Folding forwarded values in while held keeps a MEM/WB result that retires mid-stall.
      d.rs_data = op_rs;
      d.rt_data = op_rt;
`endif
    end else if (hazard) begin
      d = BUBBLE;
    end else begin
      d = id_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      q <= BUBBLE;
    else
      q <= d;
  end

  assign bus.ex_valid      = q.valid;
  assign bus.ex_reg_write  = q.reg_write;
  assign bus.ex_mem_read   = q.mem_read;
  assign bus.ex_aluop      = q.aluop;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_x          = x;
  assign bus.ex_y          = y;
  assign bus.ex_store_data = op_rt;
  assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow whichever
// forwarding configuration (ID_EX_FWD_EN) the build uses.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] sh,
                        input logic [1:0] sel, input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_aluop     = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_shamt     = sh;
    bus.id_src_sel   = sel;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic fwd_set(input logic xrw, input logic [4:0] xrd, input logic [31:0] xres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    bus.exmem_reg_write = xrw;
    bus.exmem_rd        = xrd;
    bus.exmem_result    = xres;
    bus.memwb_reg_write = wrw;
    bus.memwb_rd        = wrd;
    bus.memwb_result    = wres;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    id_set(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    fwd_set(0, 0, 0, 0, 0, 0);

    // Reset
    tick();
    tick();
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_aluop", 32'(bus.ex_aluop), 32'hd);
    check("rst_rd", 32'(bus.ex_rd), 32'd0);
    check("rst_rw", 32'(bus.ex_reg_write), 32'd0);
    check("rst_mr", 32'(bus.ex_mem_read), 32'd0);
    check("rst_x", bus.ex_x, 32'd0);
    check("rst_y", bus.ex_y, 32'd0);
    check("rst_hz", 32'(bus.hazard_stall), 32'd0);
    rst = 1'b0;

    // add rs=3 rt=4 -> EX, then forward priority
    id_set(1, 4'h2, 3, 4, 6, 32'hA, 32'hB, 0, 0, 2'b00, 1, 0);
    tick();
    id_set(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    fwd_set(1, 3, 32'h11, 1, 3, 32'h22);
    #1;
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    check("add_aluop", 32'(bus.ex_aluop), 32'h2);
    check("add_rd", 32'(bus.ex_rd), 32'd6);
    check("exmem_prio_x", bus.ex_x, FWD ? 32'h11 : 32'hA);
    check("exmem_prio_y", bus.ex_y, 32'hB);
    fwd_set(0, 0, 0, 1, 3, 32'h22);
    #1;
    check("memwb_x", bus.ex_x, FWD ? 32'h22 : 32'hA);
    fwd_set(1, 4, 32'h33, 1, 4, 32'h44);
    #1;
    check("fwd_rt_y", bus.ex_y, FWD ? 32'h33 : 32'hB);
    check("fwd_store", bus.ex_store_data, FWD ? 32'h33 : 32'hB);

    // Register 0 is never forwarded
    fwd_set(1, 0, 32'hFFFF, 1, 0, 32'hEEEE);
    id_set(1, 4'h2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    check("r0_x", bus.ex_x, 32'd0);
    check("r0_y", bus.ex_y, 32'd0);
    fwd_set(0, 0, 0, 0, 0, 0);

    // Source routing
    id_set(1, 4'h3, 2, 1, 7, 32'h55, 32'h1, 32'h1234, 5'd4, 2'b10, 0, 0);
    tick();
    check("shift_x", bus.ex_x, 32'h1);
    check("shift_y", bus.ex_y, 32'h4);
    check("shift_store", bus.ex_store_data, 32'h1);
    bus.id_src_sel = 2'b11;
    tick();
    check("sel11_x", bus.ex_x, 32'h1);
    check("sel11_y", bus.ex_y, 32'h55);
    bus.id_src_sel = 2'b01;
    tick();
    check("sel01_x", bus.ex_x, 32'h55);
    check("sel01_y", bus.ex_y, 32'h1234);

    // Load-use: lw rd=5 then use of r5
    id_set(1, 4'h2, 1, 0, 5, 32'h100, 0, 32'h4, 0, 2'b01, 1, 1);
    tick();
    id_set(1, 4'h2, 5, 2, 8, 32'h0, 32'h9, 0, 0, 2'b00, 1, 0);
    #1;
    check("lu_hz", 32'(bus.hazard_stall), 32'd1);
    tick();
    check("lu_bub_valid", 32'(bus.ex_valid), 32'd0);
    check("lu_bub_aluop", 32'(bus.ex_aluop), 32'hd);
    check("lu_hz_clear", 32'(bus.hazard_stall), 32'd0);
    tick();
    check("lu_load_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_load_rd", 32'(bus.ex_rd), 32'd8);
    check("lu_load_y", bus.ex_y, 32'h9);

    // Stall refresh: MEM/WB r4 present only on the first of three held cycles
    id_set(1, 4'h2, 3, 4, 9, 32'h10, 32'h20, 0, 0, 2'b00, 1, 0);
    tick();
    bus.stall = 1'b1;
    id_set(1, 4'h2, 1, 2, 10, 32'h1, 32'h2, 0, 0, 2'b00, 1, 0);
    fwd_set(0, 0, 0, 1, 4, 32'h7);
    tick();
    fwd_set(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    bus.stall = 1'b0;
    #1;
    check("stall_y", bus.ex_y, FWD ? 32'h7 : 32'h20);
    check("stall_rd", 32'(bus.ex_rd), 32'd9);
    check("stall_valid", 32'(bus.ex_valid), 32'd1);
    tick();
    check("post_stall_rd", 32'(bus.ex_rd), 32'd10);

    // flush beats stall
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_aluop", 32'(bus.ex_aluop), 32'hd);
    check("flush_rd", 32'(bus.ex_rd), 32'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // RAW against EX/MEM destination only stalls without forwarding
    id_set(1, 4'h2, 3, 0, 11, 0, 0, 0, 0, 2'b00, 1, 0);
    fwd_set(1, 3, 32'h5, 0, 0, 0);
    #1;
    check("exmem_raw_hz", 32'(bus.hazard_stall), FWD ? 32'd0 : 32'd1);
    fwd_set(0, 0, 0, 0, 0, 0);

    // Reset during stall
    id_set(1, 4'h4, 1, 2, 12, 32'h3, 32'h4, 0, 0, 2'b00, 1, 0);
    tick();
    check("pre_rst_rd", 32'(bus.ex_rd), 32'd12);
    bus.stall = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_stall_rd", 32'(bus.ex_rd), 32'd0);
    check("rst_stall_aluop", 32'(bus.ex_aluop), 32'hd);
    check("rst_stall_x", bus.ex_x, 32'd0);
    rst = 1'b0;
    bus.stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
